// File: rtl/clkdiv_monitor.sv
// Divided-clock checker: measures period/high time of async sig_in in clk cycles and tracks lock.
// Optional DUTY_CHECK_EN macro: lock also requires the measured high time to equal expect_hi.
module clkdiv_monitor #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CNT    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] expect_div,
  input  logic [CNT_W-1:0] expect_hi,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_VAL = MC_W'(LOCK_CNT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d;
  logic                   rise, fall;
  logic [CNT_W-1:0]       per_cnt, hi_cnt, hi_lat;
  logic [MC_W-1:0]        match_cnt, match_cnt_nxt;
  logic                   match;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      hi_lat  <= '0;
    end else begin
      if (rise)
        per_cnt <= CNT_W'(1);
      else if (per_cnt != CNT_MAX)
        per_cnt <= per_cnt + 1'b1;

      if (rise)
        hi_cnt <= CNT_W'(1);
      else if (s && hi_cnt != CNT_MAX)
        hi_cnt <= hi_cnt + 1'b1;

      if (fall)
        hi_lat <= hi_cnt;
    end
  end

  // A period of 0 or 1 is physically impossible, so those expectations never match.
  always_comb begin
    match = (per_cnt == expect_div) && (expect_div > CNT_W'(1));
`ifdef DUTY_CHECK_EN
    match = match && (hi_lat == expect_hi);
`endif
  end

`ifndef DUTY_CHECK_EN
  logic unused_expect_hi;
  assign unused_expect_hi = ^expect_hi;
`endif

  always_comb begin
    match_cnt_nxt = '0;
    if (match)
      match_cnt_nxt = (match_cnt == LOCK_VAL) ? LOCK_VAL : match_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Clear first so a same-cycle set event below takes priority.
      if (clr) begin
        err     <= 1'b0;
        timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rise)
            state <= MEAS;
        end
        MEAS: begin
          if (rise) begin
            period     <= per_cnt;
            high_time  <= hi_lat;
            meas_valid <= 1'b1;
            match_cnt  <= match_cnt_nxt;
            locked     <= (match_cnt_nxt == LOCK_VAL);
            if (!match && locked)
              err <= 1'b1;
          end else if (per_cnt == CNT_MAX) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Randomized bench for clkdiv_monitor against a period-list reference model and scoreboard.
module tb_clkdiv_monitor;
  localparam int CNT_W = 8;
  localparam int LOCK  = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             sig_in = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] expect_div = 8'd5;
  logic [CNT_W-1:0] expect_hi = 8'd3;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, err, timeout;

  clkdiv_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .sig_in(sig_in), .expect_div(expect_div),
    .expect_hi(expect_hi), .clr(clr), .period(period), .high_time(high_time),
    .meas_valid(meas_valid), .locked(locked), .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int per;
    int hi;
    bit lk;
    bit er;
  } exp_t;
  exp_t q[$];

`ifdef DUTY_CHECK_EN
  bit duty = 1'b1;
`else
  bit duty = 1'b0;
`endif

  // Reference model: a list of rise times; each rise after the first yields one measurement.
  bit m_idle = 1'b1;
  int last_rise = 0;
  int hi_prev = 0;
  int m_run = 0;
  bit m_locked = 1'b0;
  bit m_err = 1'b0;

  function automatic void model_reset();
    m_idle = 1'b1; m_run = 0; m_locked = 1'b0; m_err = 1'b0; hi_prev = 0;
    q.delete();
  endfunction

  function automatic void model_rise();
    exp_t e;
    bit   good;
    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      e.per = cyc - last_rise;
      e.hi  = hi_prev;
      good  = (e.per == int'(expect_div)) && (int'(expect_div) >= 2);
      if (duty) good = good && (e.hi == int'(expect_hi));
      if (good) begin
        m_run = (m_run < LOCK) ? m_run + 1 : LOCK;
      end else begin
        if (m_locked) m_err = 1'b1;
        m_run = 0;
      end
      m_locked = (m_run == LOCK);
      e.lk = m_locked;
      e.er = m_err;
      q.push_back(e);
    end
    last_rise = cyc;
  endfunction

  function automatic void model_timeout();
    m_idle = 1'b1; m_run = 0; m_locked = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rstn && meas_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_meas: period=%0d high=%0d at cyc %0d", period, high_time, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (period !== CNT_W'(e.per) || high_time !== CNT_W'(e.hi) ||
            locked !== e.lk || err !== e.er) begin
          miscompares++;
          $display("FAIL meas cyc %0d: got period=%0d high=%0d locked=%0d err=%0d, exp %0d %0d %0d %0d",
                   cyc, period, high_time, locked, err, e.per, e.hi, e.lk, e.er);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One sig_in pulse; clr_idx selects the cycle within the pulse that carries clr (-1 = none).
  task automatic pulse(input int hi, input int lo, input int clr_idx);
    for (int i = 0; i < hi + lo; i++) begin
      if (i == 0) begin sig_in = 1'b1; model_rise(); end
      if (i == hi) begin sig_in = 1'b0; hi_prev = hi; end
      clr = (i == clr_idx);
      if (i == clr_idx && clr_idx >= 3) m_err = 1'b0;
      step(1);
    end
    clr = 1'b0;
  endtask

  task automatic do_reset();
    step(1);
    rstn = 1'b0; sig_in = 1'b0; clr = 1'b0;
    #1;
    vectors++;
    if ({period, high_time, meas_valid, locked, err, timeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got per=%0d hi=%0d mv=%0d lk=%0d err=%0d to=%0d, exp all 0",
               period, high_time, meas_valid, locked, err, timeout);
    end
    model_reset();
    step(1);
    rstn = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_lock();
    repeat (6) pulse(3, 2, -1);
    vectors++;
    if (locked !== 1'b1 || err !== 1'b0 || period !== 8'd5 || high_time !== 8'd3) begin
      miscompares++;
      $display("FAIL lock: got locked=%0d err=%0d period=%0d high=%0d, exp 1 0 5 3",
               locked, err, period, high_time);
    end
  endtask

  task automatic test_stretch();
    pulse(3, 3, -1);
    pulse(3, 2, -1);
    step(0);
    vectors++;
    if (err !== 1'b1 || locked !== 1'b0 || period !== 8'd6) begin
      miscompares++;
      $display("FAIL stretch: got err=%0d locked=%0d period=%0d, exp 1 0 6", err, locked, period);
    end
    repeat (4) pulse(3, 2, -1);
    pulse(3, 2, -1);
    vectors++;
    if (locked !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL relock: got locked=%0d err=%0d, exp 1 1", locked, err);
    end
    pulse(3, 2, 3);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_err: got err=%0d, exp 0", err);
    end
  endtask

  task automatic test_clr_coincident();
    pulse(3, 3, -1);
    pulse(3, 2, 2);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_vs_set: got err=%0d, exp 1", err);
    end
    repeat (5) pulse(3, 2, -1);
    pulse(3, 2, 3);
  endtask

  task automatic test_timeout();
    sig_in = 1'b1; model_rise();
    step(3);
    sig_in = 1'b0; hi_prev = 3;
    step(254);
    vectors++;
    if (timeout !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got timeout=%0d locked=%0d, exp 0 1", timeout, locked);
    end
    step(1);
    vectors++;
    if (timeout !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_edge: got timeout=%0d locked=%0d, exp 1 0", timeout, locked);
    end
    model_timeout();
    step(5);
    pulse(3, 2, -1);
    pulse(3, 2, -1);
    step(0);
    vectors++;
    if (timeout !== 1'b1 || period !== 8'd5) begin
      miscompares++;
      $display("FAIL timeout_recover: got timeout=%0d period=%0d, exp 1 5", timeout, period);
    end
    repeat (4) pulse(3, 2, -1);
    pulse(3, 2, 3);
    vectors++;
    if (timeout !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_clr: got timeout=%0d locked=%0d, exp 0 1", timeout, locked);
    end
  endtask

  task automatic test_rst_mid();
    sig_in = 1'b1; model_rise();
    step(3);
    sig_in = 1'b0; hi_prev = 3;
    step(1);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({period, high_time, meas_valid, locked, err, timeout} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got per=%0d hi=%0d mv=%0d lk=%0d err=%0d to=%0d, exp all 0",
               period, high_time, meas_valid, locked, err, timeout);
    end
    model_reset();
    step(1);
    rstn = 1'b1;
    step(2);
    pulse(3, 2, -1);
    vectors++;
    if (period !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_first_rise: got period=%0d, exp 0", period);
    end
    pulse(3, 2, -1);
    vectors++;
    if (period !== 8'd5) begin
      miscompares++;
      $display("FAIL rst_second_rise: got period=%0d, exp 5", period);
    end
  endtask

  task automatic test_duty();
    do_reset();
    repeat (7) pulse(2, 3, -1);
    vectors++;
    if (locked !== !duty || high_time !== 8'd2) begin
      miscompares++;
      $display("FAIL duty: got locked=%0d high=%0d, exp %0d 2", locked, high_time, !duty);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    expect_div = 8'd1;
    repeat (7) pulse(1, 1, -1);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL div1_nolock: got locked=%0d, exp 0", locked);
    end
    do_reset();
    expect_div = 8'd2;
    expect_hi  = 8'd1;
    repeat (6) pulse(1, 1, -1);
    vectors++;
    if (locked !== 1'b1 || period !== 8'd2) begin
      miscompares++;
      $display("FAIL div2_lock: got locked=%0d period=%0d, exp 1 2", locked, period);
    end
    do_reset();
    expect_div = 8'd5;
    expect_hi  = 8'd3;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(3, 0) != 0)
        pulse(3, 2, ($urandom_range(7, 0) == 0) ? 3 : -1);
      else
        pulse(int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), -1);
    end
    step(6);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_clr_coincident();
    test_timeout();
    test_rst_mid();
    test_duty();
    test_boundary();
    test_random();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_meas: got %0d measurements outstanding, exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clkdiv_monitor.md
Name: clkdiv_monitor

Overview:
- Receive-side checker for divided clocks produced by the team's divider blocks.
- Samples an asynchronous divided-clock signal in the `clk` domain and measures its period and high time in `clk` cycles.
- Compares each measurement against an expected divide ratio and declares lock after a run of matching periods.
- Sits beside each divider instance as a built-in self-check; its status goes to the debug register bank.

Parameters:
- CNT_W, 8, width of the period/high-time counters and the expected-value inputs.
- LOCK_CNT, 4, consecutive matching periods required to assert `locked`.
- SYNC_STAGES, 2, synchronizer flops on `sig_in` (legal values 2 or 3).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- sig_in  input  1  divided clock under test; asynchronous to `clk`.
- expect_div  input  CNT_W  expected period in `clk` cycles; quasi-static.
- expect_hi  input  CNT_W  expected high time in `clk` cycles; used only with DUTY_CHECK_EN.
- clr  input  1  synchronous clear of `err` and `timeout`.
- period  output  CNT_W  last measured period.
- high_time  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse when `period`/`high_time` update.
- locked  output  1  LOCK_CNT consecutive matches seen.
- err  output  1  sticky; a mismatch occurred while `locked`.
- timeout  output  1  sticky; no rising edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset values: all outputs 0, internal counters 0, state IDLE.
- Synchronization: `sig_in` passes through a SYNC_STAGES flop chain; `s` is the last stage and `s_d` is one further delayed copy.
- Edge detection: rise = s & ~s_d; fall = ~s & s_d.
- Counters:
  - `per_cnt`: set to 1 on rise, else increments, saturating at 2^CNT_W-1.
  - `hi_cnt`: set to 1 on rise, increments while s=1 and not rise.
  - On fall, `hi_cnt` is latched into `hi_lat`.
- State IDLE: waits for the first rise, then loads the counters and goes to MEAS. No `meas_valid` is produced on this first rise.
- State MEAS, on each rise (registered, same edge):
  - `period` <= `per_cnt`.
  - `high_time` <= `hi_lat`.
  - `meas_valid` <= 1.
  - Counters reload.
- Latency: with SYNC_STAGES=2, `meas_valid` is high after the 3rd `clk` edge following a `sig_in` rise that meets setup. Add 1 cycle per extra sync stage.
- Match rule: match = (`per_cnt` == `expect_div`); the DUTY_CHECK_EN term is added when that macro is defined.
- Lock counter `match_cnt` (0..LOCK_CNT), updated on every measurement:
  - On match it increments, saturating at LOCK_CNT.
  - On mismatch it goes to 0.
  - `locked` = (`match_cnt` == LOCK_CNT), registered in the same cycle as `meas_valid`.
- Error: a mismatch while `locked`=1 sets `err` and clears `locked` in the same cycle.
- Timeout: when `per_cnt` reaches saturation in MEAS:
  - `timeout` <= 1, `locked` <= 0, `match_cnt` <= 0, state goes to IDLE.
  - `meas_valid` is not pulsed.
  - `period` and `high_time` hold their old values.
- `clr`: clears `err` and `timeout` only. If a set event occurs in the same cycle, the set wins.
- `expect_div` = 0 or 1 can never match; `locked` stays 0.
- `rstn` asserted mid-measurement: immediate return to reset values. The first rise after release is treated as an IDLE first rise.

Optional Feature:
- Macro: DUTY_CHECK_EN.
- Defined: match additionally requires `hi_lat` == `expect_hi`. A high-time mismatch is treated exactly like a period mismatch (`match_cnt` reset, `err` if locked).
- Undefined: `expect_hi` is ignored.
- `high_time` is reported and `meas_valid` is produced either way.

Test Plan:
- Divide-by-5 stimulus (3 cycles high, 2 low, synchronous to `clk`), `expect_div`=5, `expect_hi`=3 -> first `meas_valid` with `period`=5, `high_time`=3; `locked`=1 on the 4th `meas_valid`; `err`=0.
- After lock, stretch one period to 6 cycles -> that measurement gives `period`=6, `locked`=0, `err`=1; `locked` reasserts 4 good periods later; `err` holds until `clr`=1 for one cycle.
- Hold `sig_in` low after lock (CNT_W=8) -> `timeout`=1 and `locked`=0 exactly 255 cycles after the last detected rise; the next rise produces no `meas_valid`; the following rise does.
- DUTY_CHECK_EN defined, period 5 with 2 high, `expect_hi`=3 -> `meas_valid` with `high_time`=2, `locked` never asserts. Macro undefined, same stimulus -> `locked`=1 after 4 periods.
- Assert `rstn` low mid-period while locked -> all outputs 0 immediately; after release, the first rise gives no `meas_valid`; `period`=5 reported on the second rise.
- `clr` pulse in the same cycle as a new mismatch while locked -> `err` ends at 1.
